// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//   Parametrised chain of inter-stage pipeline registers. Each stage holds a
//   valid bit and a WIDTH-bit payload. Per-stage stall/flush controls are
//   combined with back-pressure from the consumer (a hold chain) and with
//   automatic bubble insertion below a held stage. Two saturating perf
//   counters track hold cycles at the entry and valid entries killed by flush.
//
//   Stage 0 is the youngest (fed by in_*), stage STAGES-1 the oldest (out_*).
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   in_valid     new entry offered to stage 0
//   in_data      payload for stage 0
//   in_ready     stage 0 accepts this cycle (= ~hold[0])
//   stall        stall[k]: register k keeps its contents
//   flush        flush[k]: register k becomes a bubble next cycle
//   out_ready    consumer accepts the oldest stage
//   out_valid    valid bit of stage STAGES-1
//   out_data     payload of stage STAGES-1
//   stage_valid  valid bit of every stage
//   stage_data   payload of every stage, stage k at [k*WIDTH +: WIDTH]
//   occupancy    number of valid stages (combinational)
//   stall_cnt    saturating count of cycles with hold[0]=1
//   flush_cnt    saturating count of valid entries killed by flush
// -----------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int STAGES     = 4,
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int SUM_W = CNT_W + OCC_W;

  logic [STAGES-1:0] validQ;
  logic [WIDTH-1:0]  dataQ [STAGES];

  logic [STAGES-1:0] hold;       // hold[k]: stage k keeps its contents
  logic [STAGES-1:0] holdUp;     // holdUp[k]: stage k-1 is frozen (0 for stage 0)
  logic [STAGES-1:0] srcValid;   // what stage k loads when it advances
  logic [WIDTH-1:0]  srcData [STAGES];

  logic [CNT_W-1:0]  stallCntQ;
  logic [CNT_W-1:0]  flushCntQ;
  logic [OCC_W-1:0]  occCount;
  logic [OCC_W-1:0]  flushHits;
  logic [SUM_W-1:0]  flushSum;

  // Hold propagates from the oldest stage towards the youngest: a stage that
  // cannot move forces everything behind it to stay put as well.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1] | (validQ[STAGES-1] & ~out_ready);
    for (int k = STAGES - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k+1];
    end
  end

  always_comb begin
    holdUp      = {hold[STAGES-2:0], 1'b0};
    srcValid    = {validQ[STAGES-2:0], in_valid};
    srcData[0]  = in_data;
    for (int k = 1; k < STAGES; k++) begin
      srcData[k] = dataQ[k-1];
    end
  end

  always_comb begin
    occCount  = '0;
    flushHits = '0;
    for (int k = 0; k < STAGES; k++) begin
      occCount  = occCount  + OCC_W'(validQ[k]);
      flushHits = flushHits + OCC_W'(validQ[k] & flush[k]);
    end
    flushSum = SUM_W'(flushCntQ) + SUM_W'(flushHits);
  end

  // Stage registers. Priority per stage: flush > hold > bubble > load.
  // NOTE: sequential state is assigned only with non-blocking (<=) so every
  // stage samples its neighbour's pre-edge value, giving a true shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      // NOTE: the payload registers are reset too, because stage_data is
      // architecturally visible and must read zero after reset.
      for (int k = 0; k < STAGES; k++) begin
        dataQ[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k]) begin
          validQ[k] <= 1'b0;
          if (CLEAR_DATA) dataQ[k] <= '0;
        end else if (hold[k]) begin
          validQ[k] <= validQ[k];
        end else if (holdUp[k]) begin
          // Upstream is frozen: advance our contents away, take a bubble.
          validQ[k] <= 1'b0;
          if (CLEAR_DATA) dataQ[k] <= '0;
        end else begin
          validQ[k] <= srcValid[k];
          dataQ[k]  <= srcData[k];
        end
      end
    end
  end

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (hold[0] && (stallCntQ != {CNT_W{1'b1}})) begin
        stallCntQ <= stallCntQ + 1'b1;
      end
      if (flushSum > SUM_W'({CNT_W{1'b1}})) begin
        flushCntQ <= {CNT_W{1'b1}};
      end else begin
        flushCntQ <= flushSum[CNT_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = dataQ[g];
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = validQ[STAGES-1];
  assign out_data    = dataQ[STAGES-1];
  assign stage_valid = validQ;
  assign occupancy   = occCount;
  assign stall_cnt   = stallCntQ;
  assign flush_cnt   = flushCntQ;

endmodule
